// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-side definitions: default widths and fetch FSM encodings.
// Also used by instruction_memory and the decoder.
package instruction_fetch_pkg;

  localparam int IF_ADDR_W = 8;
  localparam int IF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Show-ahead instruction buffer: head is valid whenever count != 0.
// Clear wins over push and pop in the same cycle.
module ifetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int W     = IF_DATA_W + IF_ADDR_W,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  input  logic                       clear,
  output logic [$clog2(DEPTH):0]     count,
  output logic [W-1:0]               head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rp;
  logic [AW-1:0] wp;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rp];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front-end: issues BRAM reads, buffers words, hands them to decode.
// Define IFETCH_STATS_EN to add saturating push/flush counters.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                ADDR_W     = IF_ADDR_W,
  parameter int                DATA_W     = IF_DATA_W,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_jump_addr,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_address,
  input  logic              i_mem_valid,
  input  logic [DATA_W-1:0] i_mem_dout,
  output logic              o_instr_valid,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
  input  logic              i_instr_ready
`ifdef IFETCH_STATS_EN
  ,
  output logic [15:0]       o_fetch_count,
  output logic [15:0]       o_flush_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = DATA_W + ADDR_W;
  localparam logic [CW:0] DEPTH_L = FIFO_DEPTH[CW:0];

  fetch_state_e      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rd_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic [CW:0]       occ;
  logic              push;
  logic              pop;
  logic              flush_go;

  // Count the outstanding response as occupied so a push always has room.
  assign occ = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign o_mem_rd = (state != ST_IDLE) && (occ < DEPTH_L);
  assign o_mem_address = fetch_pc;

  assign push = i_mem_valid && inflight
             && (state != ST_FLUSH) && !i_jump;
  assign o_instr_valid = (count != '0);
  assign pop = o_instr_valid && i_instr_ready;
  assign {o_instr, o_instr_pc} = head;

  assign flush_go = i_jump && (state != ST_IDLE)
                 && (inflight || o_mem_rd);

  ifetch_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (push),
    .din   ({i_mem_dout, rd_pc}),
    .pop   (pop),
    .clear (i_jump),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      rd_pc    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= o_mem_rd;
      if (o_mem_rd) begin
        rd_pc <= fetch_pc;
      end
      if (i_jump) begin
        fetch_pc <= i_jump_addr;
      end else if (o_mem_rd) begin
        fetch_pc <= fetch_pc + 1'b1;
      end
      unique case (1'b1)
        flush_go:          state <= ST_FLUSH;
        !flush_go && i_en: state <= ST_RUN;
        default:           state <= ST_IDLE;
      endcase
    end
  end

`ifdef IFETCH_STATS_EN
  logic drop;

  assign drop = (count != '0) || inflight || o_mem_rd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_fetch_count <= '0;
      o_flush_count <= '0;
    end else begin
      if (push && (o_fetch_count != 16'hFFFF)) begin
        o_fetch_count <= o_fetch_count + 16'd1;
      end
      if (i_jump && drop && (o_flush_count != 16'hFFFF)) begin
        o_flush_count <= o_flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed timing checks plus random traffic
// scored against a stream-level model (PC order, data, room, addresses).
module tb_instruction_fetch;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          jump;
  logic [AW-1:0] jaddr;
  logic          rd;
  logic [AW-1:0] mem_addr;
  logic          mem_valid;
  logic [DW-1:0] mem_dout;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          ready;
  logic          stray;

  int n_checks  = 0;
  int n_pass    = 0;
  int live      = 0;
  int delivered = 0;
  int d0        = 0;
  logic [AW-1:0] exp_fetch = '0;
  logic [AW-1:0] exp_pc    = '0;
  logic [AW-1:0] pcw;

  always #5 clk = ~clk;

  instruction_fetch #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (8'h00)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_jump        (jump),
    .i_jump_addr   (jaddr),
    .o_mem_rd      (rd),
    .o_mem_address (mem_addr),
    .i_mem_valid   (mem_valid),
    .i_mem_dout    (mem_dout),
    .o_instr_valid (instr_valid),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .i_instr_ready (ready)
  );

  // BRAM: mem[a] = A000 + a, one-cycle read latency.
  always @(posedge clk) begin
    mem_valid <= rd | stray;
    mem_dout  <= stray ? 16'hDEAD : 16'hA000 + {8'h00, mem_addr};
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Stream model: sequential PCs from reset/jump target, live = asked-for
  // but not yet delivered words of the current stream.
  task automatic sample();
    if (rst) begin
      exp_fetch = 8'h00;
      exp_pc    = 8'h00;
      live      = 0;
      return;
    end
    if (rd) begin
      check("rd_addr", 32'(mem_addr), 32'(exp_fetch));
      check("rd_room", 32'(live < DEPTH), 1);
    end
    if (instr_valid && ready && !jump) begin
      check("pc_order", 32'(instr_pc), 32'(exp_pc));
      check("instr_data", 32'(instr), 32'(16'hA000 + {8'h00, exp_pc}));
      exp_pc++;
      live--;
      delivered++;
    end
    if (jump) begin
      exp_fetch = jaddr;
      exp_pc    = jaddr;
      live      = 0;
    end else if (rd) begin
      exp_fetch++;
      live++;
    end
  endtask

  task automatic adv();
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    adv();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; jump = 1'b0; jaddr = '0;
    ready = 1'b0; stray = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("rst_rd", 32'(rd), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_pc", 32'(instr_pc), 0);
    adv();
    rst = 1'b0;
    step();

    // first fetch latency
    en = 1'b1; ready = 1'b1;
    @(negedge clk); check("idle_rd", 32'(rd), 0); adv();
    @(negedge clk);
    check("first_rd", 32'(rd), 1);
    check("first_addr", 32'(mem_addr), 0);
    adv();
    @(negedge clk); check("lat1_valid", 32'(instr_valid), 0); adv();
    @(negedge clk);
    check("lat2_valid", 32'(instr_valid), 1);
    check("first_instr", 32'(instr), 32'h0000A000);
    check("first_pc", 32'(instr_pc), 0);
    adv();
    repeat (8) begin
      @(negedge clk); check("stream_valid", 32'(instr_valid), 1); adv();
    end

    // decoder stall fills the buffer and stops requests
    ready = 1'b0;
    repeat (10) step();
    @(negedge clk);
    check("stall_rd", 32'(rd), 0);
    check("stall_fill", 32'(live), 4);
    check("stall_head", 32'(instr_pc), 32'(exp_pc));
    adv();

    // jump with 3 buffered and one in flight
    ready = 1'b1; step();
    ready = 1'b0;
    @(negedge clk); check("refill_rd", 32'(rd), 1); adv();
    jump = 1'b1; jaddr = 8'h40;
    @(negedge clk); check("jump_rd", 32'(rd), 0); adv();
    jump = 1'b0; ready = 1'b1;
    @(negedge clk);
    check("jmp_n1_valid", 32'(instr_valid), 0);
    check("jmp_n1_rd", 32'(rd), 1);
    check("jmp_n1_addr", 32'(mem_addr), 32'h40);
    adv();
    @(negedge clk); check("jmp_n2_valid", 32'(instr_valid), 0); adv();
    @(negedge clk);
    check("jmp_n3_valid", 32'(instr_valid), 1);
    check("jmp_n3_pc", 32'(instr_pc), 32'h40);
    check("jmp_n3_instr", 32'(instr), 32'h0000A040);
    adv();
    repeat (3) step();

    // PC wrap at the top of the address space
    jump = 1'b1; jaddr = 8'hFE; step();
    jump = 1'b0;
    repeat (2) step();
    pcw = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wrap_valid", 32'(instr_valid), 1);
      check("wrap_pc", 32'(instr_pc), 32'(pcw));
      adv();
      pcw++;
    end

    // disable with a request outstanding
    en = 1'b0;
    @(negedge clk); check("enoff_last_rd", 32'(rd), 1); adv();
    repeat (5) begin
      @(negedge clk); check("enoff_no_rd", 32'(rd), 0); adv();
    end
    check("enoff_drain", 32'(live), 0);
    en = 1'b1; step();
    @(negedge clk);
    check("resume_rd", 32'(rd), 1);
    check("resume_addr", 32'(mem_addr), 32'(exp_fetch));
    adv();

    // reset with full buffer and a request in flight
    ready = 1'b0;
    repeat (8) step();
    ready = 1'b1; step();
    ready = 1'b0;
    @(negedge clk); check("prerst_rd", 32'(rd), 1); adv();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(instr_valid), 0);
    check("mid_rst_rd", 32'(rd), 0);
    check("mid_rst_addr", 32'(mem_addr), 0);
    adv();
    rst = 1'b0; en = 1'b0; stray = 1'b1;
    step();
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk); check("stray_ignored", 32'(instr_valid), 0); adv();
    end
    en = 1'b1; step();
    @(negedge clk);
    check("refetch_rd", 32'(rd), 1);
    check("refetch_addr", 32'(mem_addr), 0);
    adv();
    step();
    @(negedge clk);
    check("refetch_valid", 32'(instr_valid), 1);
    check("refetch_pc", 32'(instr_pc), 0);
    check("refetch_instr", 32'(instr), 32'h0000A000);
    adv();

    // random traffic against the stream model
    d0 = delivered;
    for (int k = 0; k < 4000; k++) begin
      en    = ($urandom_range(0, 7) != 0);
      ready = ($urandom_range(0, 3) != 0);
      jump  = ($urandom_range(0, 19) == 0);
      jaddr = 8'($urandom);
      step();
    end
    jump = 1'b0;
    check("rand_progress", 32'((delivered - d0) > 800), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
